// File: rtl/fetch_ifid_stage.sv
// Fetch stage PC register and IF/ID pipeline register for a 5-stage MIPS pipeline.
// It honours the hazard unit's PC_write and IFID_write stall controls and the ID-stage
// branch redirect. It also keeps saturating stall and flush counters for performance debug.
module fetch_ifid_stage #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PC_write,
    input  logic                  IFID_write,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic [31:0]           imem_instr,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           IFID_instr,
    output logic [ADDR_WIDTH-1:0] IFID_pc_plus4,
    output logic                  IFID_valid,
    output logic [4:0]            IFID_rs,
    output logic [4:0]            IFID_rt,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] target_aligned;
    logic [31:0]           ifid_instr_q;
    logic [ADDR_WIDTH-1:0] ifid_pc_plus4_q;
    logic                  ifid_valid_q;
    logic [CNT_WIDTH-1:0]  stall_count_q;
    logic [CNT_WIDTH-1:0]  flush_count_q;
    logic                  stall_event;

    // The increment wraps naturally modulo 2^ADDR_WIDTH.
    // The redirect target is forced onto a word boundary.
    always_comb begin
        pc_plus4       = pc_q + ADDR_WIDTH'(4);
        target_aligned = {branch_target[ADDR_WIDTH-1:2], 2'b00};
        // A flush cycle is never counted as a stall.
        stall_event    = !branch_taken && !IFID_write;
    end

    // PC register: reset, then redirect, then advance, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (branch_taken) begin
            pc_q <= target_aligned;
        end else if (PC_write) begin
            pc_q <= pc_plus4;
        end
    end

    // IF/ID register: a redirect flushes it to a nop (one bubble), otherwise load or hold.
    always_ff @(posedge clk) begin
        if (rst || branch_taken) begin
            ifid_instr_q    <= '0;
            ifid_pc_plus4_q <= '0;
            ifid_valid_q    <= 1'b0;
        end else if (IFID_write) begin
            ifid_instr_q    <= imem_instr;
            ifid_pc_plus4_q <= pc_plus4;
            ifid_valid_q    <= 1'b1;
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (stall_event && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
            stall_count_q <= stall_count_q + CNT_WIDTH'(1);
        end
    end

    // Saturating redirect (flush) counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_count_q <= '0;
        end else if (branch_taken && (flush_count_q != {CNT_WIDTH{1'b1}})) begin
            flush_count_q <= flush_count_q + CNT_WIDTH'(1);
        end
    end

    // Outputs are driven straight from registers.
    // Only the rs/rt fields are sliced from the registered instruction.
    always_comb begin
        imem_addr     = pc_q;
        IFID_instr    = ifid_instr_q;
        IFID_pc_plus4 = ifid_pc_plus4_q;
        IFID_valid    = ifid_valid_q;
        IFID_rs       = ifid_instr_q[25:21];
        IFID_rt       = ifid_instr_q[20:16];
        stall_count   = stall_count_q;
        flush_count   = flush_count_q;
    end

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Scoreboarded bench for fetch_ifid_stage. The driver applies directed vectors and queues
// the hand-computed state expected after each edge. The monitor pops the queue and compares
// on the falling edge.
module tb_fetch_ifid_stage;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          PC_write;
    logic          IFID_write;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic [31:0]   imem_instr;
    logic [AW-1:0] imem_addr;
    logic [31:0]   IFID_instr;
    logic [AW-1:0] IFID_pc_plus4;
    logic          IFID_valid;
    logic [4:0]    IFID_rs;
    logic [4:0]    IFID_rt;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        v;
        logic [1:0]  sc;
        logic [1:0]  fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    fetch_ifid_stage #(
        .ADDR_WIDTH(AW),
        .RESET_PC  ('0),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PC_write     (PC_write),
        .IFID_write   (IFID_write),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_instr   (imem_instr),
        .imem_addr    (imem_addr),
        .IFID_instr   (IFID_instr),
        .IFID_pc_plus4(IFID_pc_plus4),
        .IFID_valid   (IFID_valid),
        .IFID_rs      (IFID_rs),
        .IFID_rt      (IFID_rt),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    // Address-tagged instruction memory.
    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h8C5A_0000;
    endfunction

    assign imem_instr = tag(imem_addr);

    task automatic chk(input int id, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", id, name, act, exp);
        end
    endtask

    // Monitor: compare the presented state against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk(mon_e.id, "imem_addr", imem_addr, mon_e.pc);
            chk(mon_e.id, "IFID_instr", IFID_instr, mon_e.instr);
            chk(mon_e.id, "IFID_pc_plus4", IFID_pc_plus4, mon_e.p4);
            chk(mon_e.id, "IFID_valid", {31'b0, IFID_valid}, {31'b0, mon_e.v});
            chk(mon_e.id, "IFID_rs", {27'b0, IFID_rs}, {27'b0, mon_e.instr[25:21]});
            chk(mon_e.id, "IFID_rt", {27'b0, IFID_rt}, {27'b0, mon_e.instr[20:16]});
            chk(mon_e.id, "stall_count", {30'b0, stall_count}, {30'b0, mon_e.sc});
            chk(mon_e.id, "flush_count", {30'b0, flush_count}, {30'b0, mon_e.fc});
        end
    end

    int step_id = 0;

    task automatic step(input logic r, input logic pcw, input logic ifw, input logic bt,
                        input logic [31:0] tgt, input logic [31:0] e_pc,
                        input logic [31:0] e_instr, input logic [31:0] e_p4, input logic e_v,
                        input logic [1:0] e_sc, input logic [1:0] e_fc);
        exp_t e;
        rst           = r;
        PC_write      = pcw;
        IFID_write    = ifw;
        branch_taken  = bt;
        branch_target = tgt;
        @(posedge clk);
        step_id++;
        e.id = step_id; e.pc = e_pc; e.instr = e_instr; e.p4 = e_p4;
        e.v = e_v; e.sc = e_sc; e.fc = e_fc;
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        // Reset overrides a simultaneous redirect.
        step(1, 1, 1, 1, 32'h40, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        // Free run.
        step(0, 1, 1, 0, 32'h0, 32'h4, tag(32'h0), 32'h4, 1, 0, 0);
        step(0, 1, 1, 0, 32'h0, 32'h8, tag(32'h4), 32'h8, 1, 0, 0);
        // Load-use stall while PC=8.
        step(0, 0, 0, 0, 32'h0, 32'h8, tag(32'h4), 32'h8, 1, 1, 0);
        step(0, 1, 1, 0, 32'h0, 32'hC, tag(32'h8), 32'hC, 1, 1, 0);
        step(0, 1, 1, 0, 32'h0, 32'h10, tag(32'hC), 32'h10, 1, 1, 0);
        // Redirect to 0x40 while PC=0x10.
        step(0, 1, 1, 1, 32'h40, 32'h40, 32'h0, 32'h0, 0, 1, 1);
        step(0, 1, 1, 0, 32'h0, 32'h44, tag(32'h40), 32'h44, 1, 1, 1);
        // Redirect during a stall, unaligned target.
        step(0, 0, 0, 1, 32'h103, 32'h100, 32'h0, 32'h0, 0, 1, 2);
        step(0, 1, 1, 0, 32'h0, 32'h104, tag(32'h100), 32'h104, 1, 1, 2);
        // Wrap-around.
        step(0, 1, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1, 3);
        step(0, 1, 1, 0, 32'h0, 32'h0, tag(32'hFFFF_FFFC), 32'h0, 1, 1, 3);
        step(0, 1, 1, 0, 32'h0, 32'h4, tag(32'h0), 32'h4, 1, 1, 3);
        // Target 0x7 aligns to 0x4; flush counter already saturated.
        step(0, 1, 1, 1, 32'h7, 32'h4, 32'h0, 32'h0, 0, 1, 3);
        step(0, 1, 1, 0, 32'h0, 32'h8, tag(32'h4), 32'h8, 1, 1, 3);
        // Disagreeing controls: fetch dropped, then same PC loaded.
        step(0, 1, 0, 0, 32'h0, 32'hC, tag(32'h4), 32'h8, 1, 2, 3);
        step(0, 0, 1, 0, 32'h0, 32'hC, tag(32'hC), 32'h10, 1, 2, 3);
        step(0, 1, 1, 0, 32'h0, 32'h10, tag(32'hC), 32'h10, 1, 2, 3);
        // Stall saturation from a clean reset.
        step(1, 1, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(0, 1, 1, 0, 32'h0, 32'h4, tag(32'h0), 32'h4, 1, 0, 0);
        step(0, 0, 0, 0, 32'h0, 32'h4, tag(32'h0), 32'h4, 1, 1, 0);
        step(0, 0, 0, 0, 32'h0, 32'h4, tag(32'h0), 32'h4, 1, 2, 0);
        step(0, 0, 0, 0, 32'h0, 32'h4, tag(32'h0), 32'h4, 1, 3, 0);
        step(0, 0, 0, 0, 32'h0, 32'h4, tag(32'h0), 32'h4, 1, 3, 0);
        step(0, 0, 0, 0, 32'h0, 32'h4, tag(32'h0), 32'h4, 1, 3, 0);
        // Reset mid-stall, with a redirect also pending.
        step(1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(0, 1, 1, 0, 32'h0, 32'h4, tag(32'h0), 32'h4, 1, 0, 0);
        step(0, 1, 1, 0, 32'h0, 32'h8, tag(32'h4), 32'h8, 1, 0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
